rounding_pipe: RTL

Pipelined, handshaked successor to the fixed single-purpose rounding block. It reduces a signed two's-complement sample from IWID to OWID bits using one of six rounding modes, selected per sample at run time. Positive overflow caused by rounding up is detected, and is either saturated or wrapped depending on configuration. It sits between arithmetic stages (filter/interpolator accumulators) and narrower downstream consumers, with full valid/ready backpressure.

---
 rtl/rounding_pkg.sv | 16 +
 rtl/round_offset.sv | 41 ++++
 rtl/rounding_pipe.sv | 103 ++++++++++
 3 files changed

// File: rtl/rounding_pkg.sv
// rounding_pkg
//   Shared definitions for the rounding pipeline: the 3-bit rounding mode
//   type and the named mode codes. Codes 6 and 7 are unnamed and behave as
//   truncate.
package rounding_pkg;

  typedef logic [2:0] rnd_mode_t;

  localparam rnd_mode_t RND_TRUNC      = 3'd0;
  localparam rnd_mode_t RND_HALFUP     = 3'd1;
  localparam rnd_mode_t RND_HALFDOWN   = 3'd2;
  localparam rnd_mode_t RND_TOZERO     = 3'd3;
  localparam rnd_mode_t RND_FROMZERO   = 3'd4;
  localparam rnd_mode_t RND_CONVERGENT = 3'd5;

endpackage

// File: rtl/round_offset.sv
// round_offset
//   Combinational offset selection. The offset is added to the input sample
//   before the low IWID-OWID bits are dropped; the choice of offset is what
//   realises each rounding mode.
// Ports:
//   mode      rounding mode of the current beat
//   sign      sign bit of the input sample
//   kept_lsb  LSB of the field that survives the drop
//   offset    IWID-bit non-negative offset
module round_offset
  import rounding_pkg::*;
#(
  parameter int IWID = 16,
  parameter int OWID = 8
) (
  input  rnd_mode_t         mode,
  input  logic              sign,
  input  logic              kept_lsb,
  output logic [IWID-1:0]   offset
);

  localparam int              D       = IWID - OWID;
  localparam logic [IWID-1:0] ONE     = {{(IWID-1){1'b0}}, 1'b1};
  localparam logic [IWID-1:0] HALF    = ONE << (D - 1);
  localparam logic [IWID-1:0] HALF_M1 = HALF - ONE;

  // HALF pushes an exact tie upward, HALF-1 leaves it below; the sign or
  // kept LSB decides which way a tie goes for the symmetric modes.
  always_comb begin
    offset = '0;
    case (mode)
      RND_HALFUP:     offset = HALF;
      RND_HALFDOWN:   offset = HALF_M1;
      RND_TOZERO:     offset = sign ? HALF : HALF_M1;
      RND_FROMZERO:   offset = sign ? HALF_M1 : HALF;
      RND_CONVERGENT: offset = kept_lsb ? HALF : HALF_M1;
      default:        offset = '0;
    endcase
  end

endmodule

// File: rtl/rounding_pipe.sv
// rounding_pipe
//   Two-stage valid/ready pipeline that rounds a signed IWID-bit sample to
//   OWID bits using a per-beat rounding mode, with sticky overflow flag.
//   Optional feature macro: ROUNDING_SAT_EN -- when defined, an overflowing
//   result saturates to the maximum positive value; otherwise it wraps.
// Ports:
//   i_clk, i_areset_n     clock, asynchronous active-low reset
//   i_valid/o_ready       input beat handshake
//   i_data, i_mode        input sample and its rounding mode
//   o_valid/i_ready       output beat handshake
//   o_data                rounded sample
//   i_clr_ovf, o_overflow sticky overflow flag and its clear
module rounding_pipe
  import rounding_pkg::*;
#(
  parameter int IWID = 16,
  parameter int OWID = 8
) (
  input  logic            i_clk,
  input  logic            i_areset_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [IWID-1:0] i_data,
  input  rnd_mode_t       i_mode,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [OWID-1:0] o_data,
  input  logic            i_clr_ovf,
  output logic            o_overflow
);

  localparam int D = IWID - OWID;

  logic [IWID-1:0] offset;
  logic [IWID:0]   sum;
  logic            s1_valid;
  logic [IWID:0]   s1_sum;
  logic            s1_adv;
  logic            s2_adv;
  logic            accept;
  logic [OWID:0]   result;
  logic            ovf;
  logic            ovf_evt;
  logic [OWID-1:0] data_next;
  logic            unused_low;

  round_offset #(
    .IWID (IWID),
    .OWID (OWID)
  ) u_round_offset (
    .mode     (i_mode),
    .sign     (i_data[IWID-1]),
    .kept_lsb (i_data[D]),
    .offset   (offset)
  );

  // Handshake: a beat moves across an interface on a cycle where valid and
  // ready are both high. Each stage advances when it is empty or the stage
  // after it advances, so o_ready depends combinationally on i_ready and
  // drops only when both stages hold a beat and downstream is stalled.
  assign s2_adv  = !o_valid || i_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign o_ready = s1_adv && i_areset_n;
  assign accept  = i_valid && o_ready;

  // One extra bit of headroom so rounding up from the top code is visible.
  assign sum = {i_data[IWID-1], i_data} + {1'b0, offset};

  assign result     = s1_sum[IWID:D];
  assign unused_low = ^s1_sum[D-1:0];
  // The offset is non-negative, so only positive overflow can show up here.
  assign ovf        = result[OWID] ^ result[OWID-1];
  assign ovf_evt    = s1_valid && s2_adv && ovf;

`ifdef ROUNDING_SAT_EN
  assign data_next = ovf ? {1'b0, {(OWID-1){1'b1}}} : result[OWID-1:0];
`else
  assign data_next = result[OWID-1:0];
`endif

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      s1_valid   <= 1'b0;
      s1_sum     <= '0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) s1_sum <= sum;
      end
      if (s2_adv) begin
        o_valid <= s1_valid;
        if (s1_valid) o_data <= data_next;
      end
      // A new overflow takes priority over a clear in the same cycle.
      if (ovf_evt)        o_overflow <= 1'b1;
      else if (i_clr_ovf) o_overflow <= 1'b0;
    end
  end

endmodule
